five_from_seven_dice: RTL and testbench
=======================================

Name: five_from_seven_dice

Overview:
- Converts a seven-sided dice source into a uniform five-sided dice output by rejection sampling.
- The source returns faces 0..6 over a req/valid handshake.
- The block pairs two source rolls into a value 0..48, accepts 0..44 and outputs that value mod 5. It rejects 45..48 and re-rolls both source dice.
- Sits between a seven-sided dice provider and any consumer that needs the five-sided dice model in synthesizable form.

Parameters:
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  level request from the consumer; sampled only in IDLE.
- valid_roll  output  1  one-cycle pulse; dice_face is valid in the same cycle.
- dice_face  output  3  five-sided result, 0..4; held between pulses.
- src_req  output  1  registered request to the seven-sided source.
- src_valid  input  1  source face valid; a beat transfers when src_req && src_valid.
- src_face  input  3  source face, legal range 0..6.
- reject_count  output  CNT_W  number of rejected pairs; saturates at all-ones.
- proto_err  output  1  sticky flag, set when src_face==7 arrives on a transferring beat.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - valid_roll=0, dice_face=0, src_req=0, reject_count=0, proto_err=0.
  - Internal f1/f2 registers=0.
  - Applying reset mid-operation abandons the roll; no valid_roll pulse follows.
- Internal state: FSM with states IDLE, FIRST, SECOND, EVAL.
- Transitions:
  - IDLE: if req=1, go to FIRST and set src_req=1; else stay.
  - FIRST: on a transferring beat with src_face<=6, capture f1=src_face and go to SECOND. src_req stays 1.
  - SECOND: on a transferring beat with src_face<=6, capture f2=src_face, go to EVAL and set src_req=0.
  - EVAL: compute combo=7*f1+f2 as an unsigned 6-bit value, range 0..48.
    - If combo<=44: dice_face=combo mod 5, pulse valid_roll=1 for one cycle, go to IDLE.
    - If combo>=45: no pulse, reject_count+=1 (saturating), set src_req=1, go to FIRST.
- Illegal beat: src_face==7 on a transferring beat in FIRST or SECOND.
  - The beat is discarded and the state is unchanged.
  - proto_err is set and stays 1 until reset.
- Latency: with src_valid held 1, valid_roll is 1 in the cycle after the 3rd rising edge following the edge that samples req=1 in IDLE.
  - Edge 0: IDLE to FIRST.
  - Edge 1: capture f1.
  - Edge 2: capture f2.
  - Edge 3: EVAL accepts and valid_roll goes high.
  - Each rejected pair adds 3 cycles.
- Throughput: with req held 1, the FSM returns through IDLE, so the maximum rate is one roll per 4 cycles.
- req handling:
  - Deasserting req after it has been sampled does not cancel the roll; the result is still delivered.
  - req is ignored outside IDLE.
- Output holding:
  - valid_roll is never high for two consecutive cycles.
  - dice_face changes only on the edge that raises valid_roll.
- Source stalls: src_valid=0 holds FIRST/SECOND indefinitely with src_req held 1. There is no timeout.
- reject_count: never wraps; stays at 2^CNT_W-1 once reached.

Test Plan:
- Reset, then req=1 with source beats f1=0, f2=3 (combo 3) -> dice_face=3 and valid_roll for one cycle, 3 edges after req is sampled; reject_count=0.
- Beats f1=6, f2=2 (combo 44) -> dice_face=4. Then beats f1=1, f2=1 (combo 8) -> dice_face=3.
- Beats f1=6, f2=3 (combo 45, rejected) then f1=1, f2=0 (combo 7) -> reject_count=1, a single valid_roll with dice_face=2, and src_req high throughout re-roll.
- src_face=7 injected in FIRST, then a beat of 2, then f2=0 -> proto_err=1, f1=2, dice_face=14 mod 5=4. proto_err still 1 on a later roll.
- Assert rst_n=0 while in SECOND -> all outputs 0 immediately with no valid_roll pulse. After release, a normal roll f1=3, f2=5 (combo 26) -> dice_face=1.
- Random source with req=1, 70000 rolls -> each face count within 14000±3%. Also check:
  - reject_count equals the number of pairs with combo>=45.
  - valid_roll is never high for 2 consecutive cycles.
  - dice_face is never >4.

Source files
------------

// File: rtl/five_from_seven_dice.sv
// Five-sided dice from a seven-sided source: pairs two source faces into 0..48,
// accepts 0..44 as (value mod 5) and re-rolls both faces on 45..48.
module five_from_seven_dice #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             valid_roll,
    output logic [2:0]       dice_face,
    output logic             src_req,
    input  logic             src_valid,
    input  logic [2:0]       src_face,
    output logic [CNT_W-1:0] reject_count,
    output logic             proto_err
);

    localparam int unsigned FACE_W  = 3;
    localparam int unsigned COMBO_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_EVAL
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [FACE_W-1:0]   r_f1,     w_f1_nxt;
    logic [FACE_W-1:0]   r_f2,     w_f2_nxt;
    logic                r_valid,  w_valid_nxt;
    logic [FACE_W-1:0]   r_face,   w_face_nxt;
    logic                r_src_req, w_src_req_nxt;
    logic [CNT_W-1:0]    r_reject, w_reject_nxt;
    logic                r_proto,  w_proto_nxt;

    logic                w_beat;
    logic                w_legal;
    logic [COMBO_W-1:0]  w_combo;
    logic                w_accept;
    logic [FACE_W-1:0]   w_mod5;

    assign w_beat   = r_src_req && src_valid;
    assign w_legal  = (src_face != 3'd7);
    assign w_combo  = COMBO_W'(r_f1) * COMBO_W'(7) + COMBO_W'(r_f2);
    assign w_accept = (w_combo <= COMBO_W'(44));
    assign w_mod5   = FACE_W'(w_combo % COMBO_W'(5));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_f1_nxt      = r_f1;
        w_f2_nxt      = r_f2;
        w_valid_nxt   = 1'b0;
        w_face_nxt    = r_face;
        w_src_req_nxt = r_src_req;
        w_reject_nxt  = r_reject;
        w_proto_nxt   = r_proto;

        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt   = S_FIRST;
                    w_src_req_nxt = 1'b1;
                end
            end
            S_FIRST: begin
                if (w_beat) begin
                    if (w_legal) begin
                        w_f1_nxt    = src_face;
                        w_state_nxt = S_SECOND;
                    end else begin
                        w_proto_nxt = 1'b1;
                    end
                end
            end
            S_SECOND: begin
                if (w_beat) begin
                    if (w_legal) begin
                        w_f2_nxt      = src_face;
                        w_state_nxt   = S_EVAL;
                        w_src_req_nxt = 1'b0;
                    end else begin
                        w_proto_nxt = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                if (w_accept) begin
                    w_face_nxt  = w_mod5;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    // Counter sticks at all-ones rather than wrapping
                    if (!(&r_reject)) begin
                        w_reject_nxt = r_reject + CNT_W'(1);
                    end
                    w_src_req_nxt = 1'b1;
                    w_state_nxt   = S_FIRST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_f1      <= '0;
            r_f2      <= '0;
            r_valid   <= 1'b0;
            r_face    <= '0;
            r_src_req <= 1'b0;
            r_reject  <= '0;
            r_proto   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_f1      <= w_f1_nxt;
            r_f2      <= w_f2_nxt;
            r_valid   <= w_valid_nxt;
            r_face    <= w_face_nxt;
            r_src_req <= w_src_req_nxt;
            r_reject  <= w_reject_nxt;
            r_proto   <= w_proto_nxt;
        end
    end

    assign valid_roll   = r_valid;
    assign dice_face    = r_face;
    assign src_req      = r_src_req;
    assign reject_count = r_reject;
    assign proto_err    = r_proto;

endmodule

// File: tb/tb_five_from_seven_dice.sv
// Scoreboard bench for five_from_seven_dice: directed pairs queue source faces and
// expected results; a monitor compares every valid_roll pulse against the queue.
module tb_five_from_seven_dice;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             req;
    logic             valid_roll;
    logic [2:0]       dice_face;
    logic             src_req;
    logic             src_valid;
    logic [2:0]       src_face;
    logic [CNT_W-1:0] reject_count;
    logic             proto_err;

    five_from_seven_dice #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .valid_roll   (valid_roll),
        .dice_face    (dice_face),
        .src_req      (src_req),
        .src_valid    (src_valid),
        .src_face     (src_face),
        .reject_count (reject_count),
        .proto_err    (proto_err)
    );

    int          n_total;
    int          n_pass;
    logic [2:0]  face_q[$];
    int          exp_q[$];
    int          exp_reject;
    int          exp_proto;
    bit          stall_en;
    bit          count_en;
    int          face_cnt[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Queue one source pair and its expected outcome
    task automatic roll(input int a, input int b);
        int combo;
        face_q.push_back(3'(a));
        face_q.push_back(3'(b));
        combo = 7 * a + b;
        if (combo <= 44) exp_q.push_back(combo % 5);
        else exp_reject++;
    endtask

    task automatic drain();
        int budget;
        budget = 40 * face_q.size() + 200;
        while ((face_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 0, 1);
        repeat (4) @(negedge clk);
    endtask

    // Source model: presents queued faces, optionally with random stalls
    initial begin
        bit xfer;
        src_valid = 1'b0;
        src_face  = 3'd0;
        forever begin
            @(negedge clk);
            if (face_q.size() != 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
                src_valid = 1'b1;
                src_face  = face_q[0];
            end else begin
                src_valid = 1'b0;
                src_face  = 3'd0;
            end
            xfer = src_valid && src_req && rst_n;
            @(posedge clk);
            if (xfer) void'(face_q.pop_front());
        end
    end

    // Monitor: compares every pulse and output-hold invariants
    initial begin
        logic       prev_vr;
        logic [2:0] prev_face;
        prev_vr   = 1'b0;
        prev_face = 3'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid_roll) begin
                    chk("no_back_to_back", 32'(prev_vr), 0);
                    chk("face_range", 32'(dice_face <= 3'd4), 1);
                    if (exp_q.size() == 0) chk("pulse_expected", 0, 1);
                    else chk("dice_face", 32'(dice_face), exp_q.pop_front());
                    if (count_en && dice_face <= 3'd4) face_cnt[dice_face]++;
                end else begin
                    chk("face_hold", 32'(dice_face), 32'(prev_face));
                end
            end
            prev_vr   = valid_roll;
            prev_face = dice_face;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0; n_pass = 0;
        exp_reject = 0; exp_proto = 0;
        stall_en = 1'b0; count_en = 1'b0;
        for (int i = 0; i < 5; i++) face_cnt[i] = 0;
        rst_n = 1'b0;
        req   = 1'b0;
        #12;
        chk("rst_valid_roll", 32'(valid_roll), 0);
        chk("rst_dice_face", 32'(dice_face), 0);
        chk("rst_src_req", 32'(src_req), 0);
        chk("rst_reject_count", 32'(reject_count), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First roll with exact latency: pulse after the 3rd edge following req sampling
        roll(0, 3);
        @(negedge clk);
        req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("latency_not_early", 32'(valid_roll), 0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_pulse", 32'(valid_roll), 1);
        drain();
        chk("reject_after_first", 32'(reject_count), 0);

        roll(6, 2);
        roll(1, 1);
        drain();
        chk("reject_after_44", 32'(reject_count), 0);

        // Rejected pair then accepted pair; DUT stalls in FIRST afterwards
        roll(6, 3);
        roll(1, 0);
        drain();
        chk("reject_count_one", 32'(reject_count), exp_reject);
        chk("src_req_stall", 32'(src_req), 1);

        // Illegal face discarded, proto_err sticky
        face_q.push_back(3'd7);
        roll(2, 0);
        exp_proto = 1;
        drain();
        chk("proto_err_set", 32'(proto_err), exp_proto);
        roll(2, 2);
        drain();
        chk("proto_err_sticky", 32'(proto_err), exp_proto);
        chk("reject_after_proto", 32'(reject_count), exp_reject);

        // Reset while waiting for the second face abandons the roll
        face_q.push_back(3'd4);
        begin
            int budget;
            budget = 100;
            while (face_q.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) chk("second_wait_timeout", 0, 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_roll", 32'(valid_roll), 0);
        chk("midrst_dice_face", 32'(dice_face), 0);
        chk("midrst_src_req", 32'(src_req), 0);
        chk("midrst_reject_count", 32'(reject_count), 0);
        chk("midrst_proto_err", 32'(proto_err), 0);
        exp_reject = 0;
        exp_proto  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        roll(3, 5);
        drain();
        chk("proto_err_after_reset", 32'(proto_err), 0);

        // Exhaustive pair sweeps with random source stalls: exact face distribution
        stall_en = 1'b1;
        count_en = 1'b1;
        for (int s = 0; s < 20; s++)
            for (int a = 0; a < 7; a++)
                for (int b = 0; b < 7; b++)
                    roll(a, b);
        drain();
        count_en = 1'b0;
        for (int i = 0; i < 5; i++) chk($sformatf("face_count_%0d", i), face_cnt[i], 180);
        chk("reject_count_sweep", 32'(reject_count), exp_reject);

        // Random faces, each pair checked by the scoreboard
        for (int n = 0; n < 500; n++) roll($urandom_range(0, 6), $urandom_range(0, 6));
        drain();
        chk("reject_count_random", 32'(reject_count), exp_reject);
        chk("proto_err_final", 32'(proto_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
